// File: rtl/prio_arbiter_4_pkg.sv
// Shared types and constants for the 4-requester priority arbiter.
// Imported by the interface, the rotating encoder and the arbiter top.
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  localparam bit FIXED       = 1'b0;
  localparam bit ROUND_ROBIN = 1'b1;

endpackage

// File: rtl/prio_arbiter_4_if.sv
// Request/grant bundle between the four clients and the arbiter.
// Clients use the master modport; the arbiter uses the slave modport.
interface prio_arbiter_4_if;
  import prio_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );

endinterface

// File: rtl/prio_arbiter_4_rot_prio_enc4.sv
// Combinational 4:2 priority encoder whose highest-priority index is 'top',
// with priority descending from top and wrapping (top, top-1, ... mod 4).
module rot_prio_enc4
  import prio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    top,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    rot_idx;

  // rot[3] = req[top], rot[2] = req[top-1], ... so a plain MSB-first scan works.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[ID_W'(top + ID_W'(gi + 1))];
    end
  endgenerate

  always_comb begin
    rot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot[i]) rot_idx = ID_W'(i);
    end
  end

  assign id  = ID_W'(rot_idx + top + ID_W'(1));
  assign any = |req;

endmodule

// File: rtl/prio_arbiter_4.sv
// Four-client arbiter: registered one-hot grant held until done, request drop
// or MAX_HOLD expiry, with fixed or round-robin priority and one idle gap.
module prio_arbiter_4
  import prio_arb_pkg::*;
#(
  parameter bit          RR_MODE  = ROUND_ROBIN,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  prio_arbiter_4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    top_q, top_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;

  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               limit_hit;
  logic               normal_rel;

  rot_prio_enc4 u_enc (
    .req (bus.req),
    .top (top_q),
    .id  (win_id),
    .any (win_any)
  );

  assign limit_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  assign normal_rel = bus.done || !bus.req[gnt_id_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      top_q     <= ID_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      top_q     <= top_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (win_any) begin
          state_d  = GRANT;
          gnt_d    = NUM_REQ'(1) << win_id;
          gnt_id_d = win_id;
          // Round-robin demotes the winner to lowest priority for the next scan.
          top_d    = RR_MODE ? ID_W'(win_id - ID_W'(1)) : ID_W'(NUM_REQ - 1);
        end
      end
      GRANT: begin
        if (normal_rel || limit_hit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          gnt_d     = '0;
          gnt_id_d  = '0;
          timeout_d = limit_hit && !normal_rel;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Directed bench: three arbiter instances (round-robin, fixed priority,
// round-robin with a 4-cycle hold limit) driven through linear steps.
module tb_prio_arbiter_4;
  import prio_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prio_arbiter_4_if ia ();
  prio_arbiter_4_if ib ();
  prio_arbiter_4_if ic ();

  prio_arbiter_4 #(.RR_MODE(ROUND_ROBIN), .MAX_HOLD(16), .CNT_W(5)) u_rr (
    .clk (clk), .rst (rst), .bus (ia)
  );
  prio_arbiter_4 #(.RR_MODE(FIXED), .MAX_HOLD(16), .CNT_W(5)) u_fix (
    .clk (clk), .rst (rst), .bus (ib)
  );
  prio_arbiter_4 #(.RR_MODE(ROUND_ROBIN), .MAX_HOLD(4), .CNT_W(3)) u_to (
    .clk (clk), .rst (rst), .bus (ic)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic t);
    chk({tag, ".gnt"},     ia.gnt,           g);
    chk({tag, ".gnt_id"},  4'(ia.gnt_id),    4'(id));
    chk({tag, ".busy"},    4'(ia.busy),      4'(b));
    chk({tag, ".timeout"}, 4'(ia.timeout),   4'(t));
  endtask

  task automatic chk_c(input string tag, input logic [3:0] g, input logic b,
                       input logic t);
    chk({tag, ".gnt"},     ic.gnt,         g);
    chk({tag, ".busy"},    4'(ic.busy),    4'(b));
    chk({tag, ".timeout"}, 4'(ic.timeout), 4'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    ia.req = '0; ia.done = 1'b0;
    ib.req = '0; ib.done = 1'b0;
    ic.req = '0; ic.done = 1'b0;

    // Reset state
    tick; tick;
    chk_a("reset_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset_b.gnt",  ib.gnt, 4'b0000);
    chk_c("reset_c", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    chk_a("idle_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    $display("step reset: gnt=%b busy=%b", ia.gnt, ia.busy);

    // Reset mid-grant clears outputs before the next edge
    ia.req = 4'b0100;
    tick;
    chk_a("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_a("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    ia.req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;
    ia.req = 4'b0001;
    tick;
    chk_a("post_rst_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    ia.req = 4'b0000;
    tick;
    chk_a("req_drop_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    $display("step mid-grant reset: gnt=%b", ia.gnt);

    // Round-robin rotation with done after two grant cycles
    ia.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk_a($sformatf("rr%0d_c1", k), 4'(4'b0001 << rr_seq[k]), rr_seq[k], 1'b1, 1'b0);
      tick;
      chk_a($sformatf("rr%0d_c2", k), 4'(4'b0001 << rr_seq[k]), rr_seq[k], 1'b1, 1'b0);
      ia.done = 1'b1;
      tick;
      chk_a($sformatf("rr%0d_gap", k), 4'b0000, 2'd0, 1'b0, 1'b0);
      ia.done = 1'b0;
      $display("step rr grant %0d: expected id %0d", k, rr_seq[k]);
    end
    ia.req = 4'b0000;
    tick;

    // Late request from client 1 while client 3 owns (top is now 2)
    ia.req = 4'b1000;
    tick;
    chk_a("late_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    ia.req = 4'b1010;
    tick;
    chk_a("late_ignored", 4'b1000, 2'd3, 1'b1, 1'b0);
    ia.req = 4'b0010;
    ia.done = 1'b1;
    tick;
    chk_a("late_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    ia.done = 1'b0;
    ia.req = 4'b1010;
    tick;
    chk_a("late_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    ia.req = 4'b0000;
    tick;
    chk_a("late_end", 4'b0000, 2'd0, 1'b0, 1'b0);
    $display("step late request: client 1 granted ahead of client 3");

    // Fixed priority: client 3 always beats client 1
    ib.req = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk($sformatf("fix%0d_gnt", k), ib.gnt, 4'b1000);
      chk($sformatf("fix%0d_id", k), 4'(ib.gnt_id), 4'd3);
      ib.done = 1'b1;
      tick;
      chk($sformatf("fix%0d_gap", k), ib.gnt, 4'b0000);
      ib.done = 1'b0;
      $display("step fixed grant %0d: gnt=1000 then 0000 expected", k);
    end
    ib.req = 4'b0000;
    tick;

    // Hold limit: four cycles then timeout pulse with the release
    ic.req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk_c($sformatf("to_c%0d", c), 4'b0100, 1'b1, 1'b0);
    end
    tick;
    chk_c("to_release", 4'b0000, 1'b0, 1'b1);
    tick;
    chk_c("to_regrant", 4'b0100, 1'b1, 1'b0);
    $display("step timeout: 4-cycle grant, pulse, regrant");

    // done coincides with the limit: normal release, no timeout
    tick;
    chk_c("col_c2", 4'b0100, 1'b1, 1'b0);
    tick;
    chk_c("col_c3", 4'b0100, 1'b1, 1'b0);
    tick;
    chk_c("col_c4", 4'b0100, 1'b1, 1'b0);
    ic.done = 1'b1;
    tick;
    chk_c("col_release", 4'b0000, 1'b0, 1'b0);
    ic.done = 1'b0;
    tick;
    chk_c("col_regrant", 4'b0100, 1'b1, 1'b0);
    tick;
    ic.req = 4'b0000;
    tick;
    chk_c("drop_release", 4'b0000, 1'b0, 1'b0);
    tick;
    chk_c("drop_idle", 4'b0000, 1'b0, 1'b0);
    $display("step collision/drop: release without timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
